karatsuba_mul256: RTL and testbench



---
 rtl/karatsuba_mul256.sv | 167 ++++++++++++++++
 tb/tb_karatsuba_mul256.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_mul256.sv
// 256x256 -> 512-bit unsigned multiplier: two-level Karatsuba over 64-bit limbs, one shared 66x66 multiplier.
// Latency 10 edges from capture to out_valid; one product per 12 cycles. Debug taps gated by KARATSUBA_DEBUG_EN.
module karatsuba_mul256 (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [255:0] Xin,
    input  logic [255:0] Yin,
    output logic         out_valid,
    output logic [511:0] P,
    output logic [127:0] P00,
    output logic [127:0] T0K_1,
    output logic [127:0] T0K_2,
    output logic [63:0]  result_3
);

    typedef enum logic [1:0] {IDLE, MUL, COMB, DONE} state_t;

    state_t              state_q;
    logic [3:0]          k_q;
    logic [255:0]        x_q;
    logic [255:0]        y_q;
    logic [8:0][131:0]   sp_q;
    logic [511:0]        p_q;
    logic                out_valid_q;

    logic [128:0]        src_x;
    logic [128:0]        src_y;
    logic [1:0]          limb_sel_d;
    logic [65:0]         mul_a;
    logic [65:0]         mul_b;
    logic [131:0]        mul_d;
    logic [257:0]        pll_d;
    logic [257:0]        phh_d;
    logic [257:0]        pmm_d;
    logic [257:0]        m_d;
    logic [511:0]        p_d;

    // sel 0: low 64-bit limb, 1: high limb (up to 65 bits), 2: limb sum (up to 66 bits)
    function automatic logic [65:0] limb_pick(input logic [128:0] v, input logic [1:0] sel);
        logic [65:0] lo;
        logic [65:0] hi;
        lo = {2'b00, v[63:0]};
        hi = {1'b0, v[128:64]};
        case (sel)
            2'd0:    return lo;
            2'd1:    return hi;
            default: return lo + hi;
        endcase
    endfunction

    function automatic logic [257:0] kara(input logic [131:0] lo, input logic [131:0] hi,
                                          input logic [131:0] mid);
        logic [257:0] l;
        logic [257:0] h;
        logic [257:0] m;
        l = {126'd0, lo};
        h = {126'd0, hi};
        m = {126'd0, mid};
        return (h << 128) + ((m - l - h) << 64) + l;
    endfunction

    always_comb begin
        case (k_q)
            4'd0, 4'd1, 4'd2: begin
                src_x = {1'b0, x_q[127:0]};
                src_y = {1'b0, y_q[127:0]};
            end
            4'd3, 4'd4, 4'd5: begin
                src_x = {1'b0, x_q[255:128]};
                src_y = {1'b0, y_q[255:128]};
            end
            default: begin
                src_x = {1'b0, x_q[127:0]} + {1'b0, x_q[255:128]};
                src_y = {1'b0, y_q[127:0]} + {1'b0, y_q[255:128]};
            end
        endcase
        case (k_q)
            4'd0, 4'd3, 4'd6: limb_sel_d = 2'd0;
            4'd1, 4'd4, 4'd7: limb_sel_d = 2'd1;
            default:          limb_sel_d = 2'd2;
        endcase
        mul_a = limb_pick(src_x, limb_sel_d);
        mul_b = limb_pick(src_y, limb_sel_d);
        mul_d = {66'd0, mul_a} * {66'd0, mul_b};

        pll_d = kara(sp_q[0], sp_q[1], sp_q[2]);
        phh_d = kara(sp_q[3], sp_q[4], sp_q[5]);
        pmm_d = kara(sp_q[6], sp_q[7], sp_q[8]);
        m_d   = pmm_d - pll_d - phh_d;
        p_d   = ({254'd0, phh_d} << 256) + ({254'd0, m_d} << 128) + {254'd0, pll_d};
    end

`ifdef KARATSUBA_DEBUG_EN
    logic [127:0] p00_q;
    logic [127:0] t0k_1_q;
    logic [127:0] t0k_2_q;
    logic [63:0]  result_3_q;
    assign P00      = p00_q;
    assign T0K_1    = t0k_1_q;
    assign T0K_2    = t0k_2_q;
    assign result_3 = result_3_q;
`else
    assign P00      = '0;
    assign T0K_1    = '0;
    assign T0K_2    = '0;
    assign result_3 = '0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            sp_q        <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
`ifdef KARATSUBA_DEBUG_EN
            p00_q       <= '0;
            t0k_1_q     <= '0;
            t0k_2_q     <= '0;
            result_3_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    if (in_valid) begin
                        x_q     <= Xin;
                        y_q     <= Yin;
                        k_q     <= '0;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    sp_q[k_q] <= mul_d;
                    if (k_q == 4'd8) begin
                        state_q <= COMB;
                    end else begin
                        k_q <= k_q + 4'd1;
                    end
                end
                COMB: begin
                    p_q         <= p_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
`ifdef KARATSUBA_DEBUG_EN
                    // sp_q[3] is the low-limb product of the upper 128-bit halves
                    p00_q       <= sp_q[0][127:0];
                    t0k_1_q     <= sp_q[1][127:0];
                    t0k_2_q     <= sp_q[3][127:0];
                    result_3_q  <= m_d[63:0];
`endif
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign P         = p_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_karatsuba_mul256.sv
// Directed-vector bench for karatsuba_mul256: product, latency, pulse width, back-to-back and mid-op reset.
module tb_karatsuba_mul256;

    logic         clock;
    logic         reset;
    logic         in_valid;
    logic [255:0] Xin;
    logic [255:0] Yin;
    logic         out_valid;
    logic [511:0] P;
    logic [127:0] P00;
    logic [127:0] T0K_1;
    logic [127:0] T0K_2;
    logic [63:0]  result_3;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [255:0] x;
        logic [255:0] y;
        logic [511:0] p;
        logic [127:0] p00;
        logic [127:0] t1;
        logic [127:0] t2;
        logic [63:0]  r3;
    } vec_t;

    vec_t vecs[6];

    karatsuba_mul256 dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .Xin      (Xin),
        .Yin      (Yin),
        .out_valid(out_valid),
        .P        (P),
        .P00      (P00),
        .T0K_1    (T0K_1),
        .T0K_2    (T0K_2),
        .result_3 (result_3)
    );

    initial begin
        clock = 1'b1;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    function automatic logic [511:0] mdl_p(input logic [255:0] x, input logic [255:0] y);
        return {256'd0, x} * {256'd0, y};
    endfunction

    function automatic logic [63:0] mdl_m(input logic [255:0] x, input logic [255:0] y);
        logic [257:0] xl, xh, yl, yh, m;
        xl = {130'd0, x[127:0]};
        xh = {130'd0, x[255:128]};
        yl = {130'd0, y[127:0]};
        yh = {130'd0, y[255:128]};
        m  = (xl + xh) * (yl + yh) - xl * yl - xh * yh;
        return m[63:0];
    endfunction

    function automatic logic [127:0] mdl_limb(input logic [63:0] a, input logic [63:0] b);
        return {64'd0, a} * {64'd0, b};
    endfunction

    function automatic vec_t mk_model(input logic [255:0] x, input logic [255:0] y);
        vec_t v;
        v.x   = x;
        v.y   = y;
        v.p   = mdl_p(x, y);
        v.p00 = mdl_limb(x[63:0], y[63:0]);
        v.t1  = mdl_limb(x[127:64], y[127:64]);
        v.t2  = mdl_limb(x[191:128], y[191:128]);
        v.r3  = mdl_m(x, y);
        return v;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_dbg(input string tag, input logic [127:0] e00, input logic [127:0] e1,
                           input logic [127:0] e2, input logic [63:0] er3);
`ifdef KARATSUBA_DEBUG_EN
        chk({tag, "_P00"},      512'(P00),      512'(e00));
        chk({tag, "_T0K_1"},    512'(T0K_1),    512'(e1));
        chk({tag, "_T0K_2"},    512'(T0K_2),    512'(e2));
        chk({tag, "_result_3"}, 512'(result_3), 512'(er3));
`else
        chk({tag, "_P00"},      512'(P00),      512'(0));
        chk({tag, "_T0K_1"},    512'(T0K_1),    512'(0));
        chk({tag, "_T0K_2"},    512'(T0K_2),    512'(0));
        chk({tag, "_result_3"}, 512'(result_3), 512'(0));
        if (0) chk({tag, "_unused"}, 512'({e00, e1, e2, er3}), 512'(0));
`endif
    endtask

    // Called at a negedge with the DUT idle; returns at the next negedge, DUT idle again.
    task automatic run_op(input string tag, input vec_t v);
        int lat;
        Xin      = v.x;
        Yin      = v.y;
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        Xin      = ~v.x;
        Yin      = v.y ^ 256'h5A5A;
        lat = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clock);
            #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        chk({tag, "_latency"}, 512'(lat), 512'(10));
        chk({tag, "_P"}, P, v.p);
        chk_dbg(tag, v.p00, v.t1, v.t2, v.r3);
        @(posedge clock);
        #1;
        chk({tag, "_pulse_end"}, 512'(out_valid), 512'(0));
        @(negedge clock);
    endtask

    logic [255:0] hx[48];
    logic [255:0] hy[48];
    int           n_res;
    int           n_pulse;

    initial begin
        vecs[0].x = '1;
        vecs[0].y = '1;
        vecs[0].p = {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1};
        vecs[0].p00 = 128'hFFFFFFFFFFFFFFFE0000000000000001;
        vecs[0].t1  = 128'hFFFFFFFFFFFFFFFE0000000000000001;
        vecs[0].t2  = 128'hFFFFFFFFFFFFFFFE0000000000000001;
        vecs[0].r3  = 64'd2;

        vecs[1].x = 256'd2;
        vecs[1].y = 256'd3;
        vecs[1].p = 512'd6;
        vecs[1].p00 = 128'd6;
        vecs[1].t1  = 128'd0;
        vecs[1].t2  = 128'd0;
        vecs[1].r3  = 64'd0;

        vecs[2].x = 256'd0;
        vecs[2].y = 256'h8000_0000_0000_0001_FFFF_FFFF_FFFF_FFFF_7FFF_FFFF_FFFF_FFFF_0000_0001_0000_0000;
        vecs[2].p = 512'd0;
        vecs[2].p00 = 128'd0;
        vecs[2].t1  = 128'd0;
        vecs[2].t2  = 128'd0;
        vecs[2].r3  = 64'd0;

        vecs[3].x = 256'd1 << 255;
        vecs[3].y = 256'd1 << 255;
        vecs[3].p = 512'd1 << 510;
        vecs[3].p00 = 128'd0;
        vecs[3].t1  = 128'd0;
        vecs[3].t2  = 128'd0;
        vecs[3].r3  = 64'd0;

        vecs[4] = mk_model(
            256'd68374361576449959379811878238702970795767227995234058958640265755013581201577,
            256'd69709006495262083753438964270882567809667203355268795714903518762464260067737);
        vecs[5] = mk_model(
            256'hC3A5_9F10_7E2D_4B86_11F0_AA55_0F0F_F0F0_1357_9BDF_2468_ACE0_DEAD_BEEF_CAFE_F00D,
            256'h8000_0000_0000_0001_FFFF_FFFF_FFFF_FFFF_7FFF_FFFF_FFFF_FFFF_0000_0001_0000_0000);

        reset    = 1'b0;
        in_valid = 1'b0;
        Xin      = '0;
        Yin      = '0;
        #12;
        chk("rst_P", P, 512'd0);
        chk("rst_out_valid", 512'(out_valid), 512'd0);
        chk_dbg("rst", 128'd0, 128'd0, 128'd0, 64'd0);
        #3;
        reset = 1'b1;

        for (int i = 0; i < 6; i++) run_op($sformatf("vec%0d", i), vecs[i]);

        // in_valid held high, fresh operands every cycle
        n_res = 0;
        for (int c = 0; c < 48; c++) begin
            @(negedge clock);
            hx[c] = rnd256();
            hy[c] = rnd256();
            Xin = hx[c];
            Yin = hy[c];
            in_valid = 1'b1;
            @(posedge clock);
            #1;
            if (out_valid) begin
                chk("b2b_slot", 512'(c), 512'(10 + 12 * n_res));
                n_res++;
                if (c >= 10) chk("b2b_P", P, mdl_p(hx[c-10], hy[c-10]));
            end
        end
        @(negedge clock);
        in_valid = 1'b0;
        chk("b2b_count", 512'(n_res), 512'd4);

        // reset asserted while k=4 is pending
        Xin      = vecs[4].x;
        Yin      = vecs[4].y;
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midrst_P", P, 512'd0);
        chk("midrst_out_valid", 512'(out_valid), 512'd0);
        chk_dbg("midrst", 128'd0, 128'd0, 128'd0, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        n_pulse = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clock);
            #1;
            if (out_valid) n_pulse++;
        end
        chk("midrst_no_pulse", 512'(n_pulse), 512'd0);
        chk("midrst_P_held", P, 512'd0);
        @(negedge clock);
        run_op("post_rst", vecs[5]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
